// File: rtl/step_clock_gen.sv
// Debounces the board push-buttons and shapes a clean single-step CPU clock.
// Optional auto-run mode (KEY2 toggles periodic steps) is built when STEP_AUTO_RUN_EN is defined.
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CLK_HIGH_CYCLES = 25_000,
  parameter int unsigned RUN_DIV         = 25_000_000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_step_n,
  input  logic             key_run_n,
  output logic             cpu_clock,
  output logic             step_pulse,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HiW = $clog2(CLK_HIGH_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HiW-1:0] HiLast = HiW'(CLK_HIGH_CYCLES - 1);

`ifdef STEP_AUTO_RUN_EN
  localparam int unsigned NumKeys = 2;
  logic [NumKeys-1:0] key_raw;
  assign key_raw = {key_run_n, key_step_n};
`else
  localparam int unsigned NumKeys = 1;
  logic [NumKeys-1:0] key_raw;
  logic               unused_cfg;
  assign key_raw    = key_step_n;
  assign unused_cfg = key_run_n ^ (RUN_DIV == 0);
`endif

  typedef enum logic [1:0] {DbIdle, DbPressChk, DbPressed, DbRelChk} db_state_e;
  typedef enum logic [1:0] {ShReady, ShHigh, ShLowGuard} sh_state_e;

  logic [NumKeys-1:0] key_evt;

  // Per key: 2-flop synchroniser feeding a debounce FSM; one event per accepted press.
  for (genvar k = 0; k < NumKeys; k++) begin : g_key
    logic           sync1_q;
    logic           sync2_q;
    logic           evt_q;
    db_state_e      state_q;
    logic [DbW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        state_q <= DbIdle;
        cnt_q   <= '0;
        evt_q   <= 1'b0;
      end else begin
        sync1_q <= key_raw[k];
        sync2_q <= sync1_q;
        evt_q   <= 1'b0;
        unique case (state_q)
          DbIdle: begin
            if (!sync2_q) begin
              state_q <= DbPressChk;
              cnt_q   <= '0;
            end
          end
          DbPressChk: begin
            if (sync2_q) begin
              state_q <= DbIdle;
            end else if (cnt_q == DbLast) begin
              state_q <= DbPressed;
              evt_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + DbW'(1);
            end
          end
          DbPressed: begin
            if (sync2_q) begin
              state_q <= DbRelChk;
              cnt_q   <= '0;
            end
          end
          DbRelChk: begin
            if (!sync2_q) begin
              state_q <= DbPressed;
            end else if (cnt_q == DbLast) begin
              state_q <= DbIdle;
            end else begin
              cnt_q <= cnt_q + DbW'(1);
            end
          end
          default: state_q <= DbIdle;
        endcase
      end
    end

    assign key_evt[k] = evt_q;
  end

  logic step_req;

`ifdef STEP_AUTO_RUN_EN
  localparam int unsigned RunW = $clog2(RUN_DIV + 1);
  localparam logic [RunW-1:0] RunLast = RunW'(RUN_DIV - 1);

  logic            run_mode_q;
  logic [RunW-1:0] run_cnt_q;
  logic            run_tick;

  // Tick is combinational so a same-cycle toggle still sees the old run_mode.
  assign run_tick = run_mode_q && (run_cnt_q == RunLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_mode_q <= 1'b0;
      run_cnt_q  <= '0;
    end else begin
      if (key_evt[1]) begin
        run_mode_q <= ~run_mode_q;
      end
      if (!run_mode_q || run_tick) begin
        run_cnt_q <= '0;
      end else begin
        run_cnt_q <= run_cnt_q + RunW'(1);
      end
    end
  end

  assign run_mode = run_mode_q;
  assign step_req = run_mode_q ? run_tick : key_evt[0];
`else
  assign run_mode = 1'b0;
  assign step_req = key_evt[0];
`endif

  // Clock shaper: requests outside ShReady are dropped, never queued.
  sh_state_e      sh_state_q;
  logic [HiW-1:0] hi_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_state_q <= ShReady;
      hi_cnt_q   <= '0;
      cpu_clock  <= 1'b0;
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      step_pulse <= 1'b0;
      unique case (sh_state_q)
        ShReady: begin
          if (step_req) begin
            sh_state_q <= ShHigh;
            hi_cnt_q   <= '0;
            cpu_clock  <= 1'b1;
            step_pulse <= 1'b1;
            step_count <= step_count + CNT_W'(1);
          end
        end
        ShHigh: begin
          if (hi_cnt_q == HiLast) begin
            sh_state_q <= ShLowGuard;
            hi_cnt_q   <= '0;
            cpu_clock  <= 1'b0;
          end else begin
            hi_cnt_q <= hi_cnt_q + HiW'(1);
          end
        end
        ShLowGuard: begin
          if (hi_cnt_q == HiLast) begin
            sh_state_q <= ShReady;
          end else begin
            hi_cnt_q <= hi_cnt_q + HiW'(1);
          end
        end
        default: begin
          sh_state_q <= ShReady;
          cpu_clock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen: vector table plus directed multi-cycle sequences.
module tb_step_clock_gen;

  logic       clk;
  logic       rst_n, key_step_n, key_run_n;
  logic       cpu_clock, step_pulse, run_mode;
  logic [3:0] step_count;

  // Second instance with a 1-cycle debounce so two accepted presses can land close together.
  logic       f_rst_n, f_key_step_n, f_key_run_n;
  logic       f_cpu_clock, f_step_pulse, f_run_mode;
  logic [3:0] f_step_count;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(4),
    .CLK_HIGH_CYCLES(3),
    .RUN_DIV        (20),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_step_n(key_step_n),
    .key_run_n (key_run_n),
    .cpu_clock (cpu_clock),
    .step_pulse(step_pulse),
    .run_mode  (run_mode),
    .step_count(step_count)
  );

  step_clock_gen #(
    .DEBOUNCE_CYCLES(1),
    .CLK_HIGH_CYCLES(3),
    .RUN_DIV        (20),
    .CNT_W          (4)
  ) dut_fast (
    .clk       (clk),
    .rst_n     (f_rst_n),
    .key_step_n(f_key_step_n),
    .key_run_n (f_key_run_n),
    .cpu_clock (f_cpu_clock),
    .step_pulse(f_step_pulse),
    .run_mode  (f_run_mode),
    .step_count(f_step_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       key_step_n;
    logic       key_run_n;
    logic       exp_cpu;
    logic       exp_pulse;
    logic [3:0] exp_cnt;
    logic       exp_run;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    key_step_n = 1'b1;
    key_run_n  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic ks, input logic ec, input logic ep,
                              input logic [3:0] cnt);
    vec_t v;
    v.rst_n      = r;
    v.key_step_n = ks;
    v.key_run_n  = 1'b1;
    v.exp_cpu    = ec;
    v.exp_pulse  = ep;
    v.exp_cnt    = cnt;
    v.exp_run    = 1'b0;
    return v;
  endfunction

  int pulses, run_len, max_run, first, fcpu;
  int q[$];
  int exp_q[$];
  logic [5:0] fpat;

  initial begin
    rst_n        = 1'b0;
    key_step_n   = 1'b1;
    key_run_n    = 1'b1;
    f_rst_n      = 1'b0;
    f_key_step_n = 1'b1;
    f_key_run_n  = 1'b1;

    // Vector table: test 1 (held press) and test 2 (bouncing key); row j = state after edge j+1.
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int j = 0; j < 20; j++)
      vecs.push_back(mk(1'b1, 1'b0, (j >= 7 && j <= 9), (j == 7), (j >= 7) ? 4'd1 : 4'd0));
    for (int j = 0; j < 10; j++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd1));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
    for (int j = 0; j < 30; j++)
      vecs.push_back(mk(1'b1, ((j / 2) % 2 == 1), 1'b0, 1'b0, 4'd0));
    for (int j = 0; j < 10; j++) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0));

    foreach (vecs[i]) begin
      rst_n      = vecs[i].rst_n;
      key_step_n = vecs[i].key_step_n;
      key_run_n  = vecs[i].key_run_n;
      tick();
      check($sformatf("vec%0d cpu_clock", i), 32'(cpu_clock), 32'(vecs[i].exp_cpu));
      check($sformatf("vec%0d step_pulse", i), 32'(step_pulse), 32'(vecs[i].exp_pulse));
      check($sformatf("vec%0d step_count", i), 32'(step_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d run_mode", i), 32'(run_mode), 32'(vecs[i].exp_run));
    end

    // Test 3: 17 clean presses wrap the 4-bit counter; high phase never exceeds 3 cycles.
    apply_reset();
    pulses  = 0;
    run_len = 0;
    max_run = 0;
    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < 24; c++) begin
        key_step_n = (c >= 10);
        tick();
        if (step_pulse) pulses++;
        if (cpu_clock) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
        end
      end
    end
    check("t3 pulses", pulses, 17);
    check("t3 wrapped step_count", 32'(step_count), 1);
    check("t3 max high run", max_run, 3);

    // Test 4: second accepted press lands while the shaper is guarding low and is dropped.
    f_key_step_n = 1'b1;
    tick();
    f_rst_n = 1'b1;
    fpat    = 6'b001100;  // bit n-1 = key level for edge n
    q.delete();
    fcpu = 0;
    for (int n = 1; n <= 20; n++) begin
      f_key_step_n = (n <= 6) ? fpat[n-1] : 1'b0;
      tick();
      if (f_step_pulse) q.push_back(n);
      if (f_cpu_clock) fcpu++;
    end
    check("t4 pulse count", q.size(), 1);
    check("t4 pulse edge", (q.size() > 0) ? q[0] : -1, 5);
    check("t4 step_count", 32'(f_step_count), 1);
    check("t4 high cycles", fcpu, 3);
    check("t4 run_mode", 32'(f_run_mode), 0);

    // Test 5: reset in the 2nd high cycle drops the clock at that edge.
    apply_reset();
    key_step_n = 1'b0;
    for (int n = 1; n <= 9; n++) tick();
    check("t5 high before reset", 32'(cpu_clock), 1);
    rst_n      = 1'b0;
    key_step_n = 1'b1;
    tick();
    check("t5 cpu_clock at reset", 32'(cpu_clock), 0);
    check("t5 step_count at reset", 32'(step_count), 0);
    check("t5 step_pulse at reset", 32'(step_pulse), 0);
    rst_n  = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (step_pulse) pulses++;
    end
    check("t5 no pulse after reset", pulses, 0);
    key_step_n = 1'b0;
    first      = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (step_pulse) begin
        pulses++;
        first = n;
      end
    end
    check("t5 new press pulses", pulses, 1);
    check("t5 new press latency", first, 8);
    check("t5 new press count", 32'(step_count), 1);

    // Test 6: key_run presses toggle auto-run; manual press in run mode is ignored.
    apply_reset();
    q.delete();
    for (int n = 1; n <= 120; n++) begin
      key_run_n  = !((n >= 1 && n <= 10) || (n >= 75 && n <= 84));
      key_step_n = !(n >= 30 && n <= 39);
      tick();
      if (step_pulse) q.push_back(n);
`ifdef STEP_AUTO_RUN_EN
      if (n == 7)  check("t6 run_mode before toggle", 32'(run_mode), 0);
      if (n == 8)  check("t6 run_mode on", 32'(run_mode), 1);
      if (n == 81) check("t6 run_mode still on", 32'(run_mode), 1);
      if (n == 82) check("t6 run_mode off", 32'(run_mode), 0);
`else
      if (n == 8 || n == 50 || n == 82) check($sformatf("t6 run_mode n%0d", n), 32'(run_mode), 0);
`endif
    end
`ifdef STEP_AUTO_RUN_EN
    exp_q = '{28, 48, 68};
    check("t6 step_count", 32'(step_count), 3);
`else
    exp_q = '{37};
    check("t6 step_count", 32'(step_count), 1);
`endif
    check("t6 pulse count", q.size(), exp_q.size());
    foreach (exp_q[k])
      check($sformatf("t6 pulse%0d edge", k), (k < q.size()) ? q[k] : -1, exp_q[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
